// File: rtl/div.sv
// ---------------------------------------------------------------------------
// div -- iterative 32-bit integer divider for the EX stage (M extension
// DIV / DIVU / REM / REMU). Restoring shift-subtract, one quotient bit per
// cycle on unsigned magnitudes. Signs are fixed up on the final step.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start_i     EX stage holds a divide/remainder op
//   op_i        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i  rs1, sampled only when an op is accepted
//   divisor_i   rs2, sampled only when an op is accepted
//   annul_i     flush of the EX-stage instruction
//   hold_i      EX stage frozen by a downstream stall
//   result_o    quotient or remainder (0 outside DONE)
//   ready_o     result_o valid
//   stallreq_o  stall request to the pipeline controller
// ---------------------------------------------------------------------------
module div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        annul_i,
    input  logic        hold_i,
    output logic [31:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] quo;        // dividend magnitude shifts out, quotient shifts in
    logic [31:0] dvs;        // divisor magnitude
    logic [32:0] rem;        // partial remainder
    logic        is_rem;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] result;
    logic        ready;

    // ---- operand decode at start ----
    logic        op_signed;
    logic        div_zero;
    logic        ovf;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] early_res;

    assign op_signed = ~op_i[0];
    assign div_zero  = (divisor_i == 32'd0);
    assign ovf       = op_signed && (dividend_i == 32'h8000_0000) &&
                       (divisor_i == 32'hFFFF_FFFF);
    assign a_mag     = (op_signed && dividend_i[31]) ? -dividend_i : dividend_i;
    assign b_mag     = (op_signed && divisor_i[31])  ? -divisor_i  : divisor_i;

    // Result for the ops that bypass iteration.
    always_comb begin
        early_res = 32'd0;
        if (div_zero)
            early_res = op_i[1] ? dividend_i : 32'hFFFF_FFFF;
        else
            early_res = op_i[1] ? 32'd0 : 32'h8000_0000;
    end

    // ---- one restoring step ----
    // rem < dvs always holds, so the shifted value fits in 33 bits; the
    // extra top bit of the 34-bit difference is the borrow.
    logic [33:0] rem_sh;
    logic [33:0] diff;
    logic        take;
    logic [32:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] q_fin;
    logic [31:0] r_fin;
    logic [31:0] res_fin;

    assign rem_sh   = {rem, quo[31]};
    assign diff     = rem_sh - {2'b00, dvs};
    assign take     = ~diff[33];
    assign rem_step = take ? diff[32:0] : rem_sh[32:0];
    assign quo_step = {quo[30:0], take};
    assign q_fin    = neg_q ? -quo_step : quo_step;
    assign r_fin    = neg_r ? -rem_step[31:0] : rem_step[31:0];
    assign res_fin  = is_rem ? r_fin : q_fin;

    // ---- FSM ----
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        stallreq_o = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    stallreq_o = 1'b1;
                    state_nxt  = (div_zero || ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                stallreq_o = 1'b1;
                if (cnt == 5'd31) state_nxt = DONE;
            end
            DONE: begin
                if (!hold_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Flush overrides everything below reset.
        if (annul_i) begin
            state_nxt  = IDLE;
            stallreq_o = 1'b0;
        end
        if (!rst_n) stallreq_o = 1'b0;
    end

    // ---- datapath ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= 5'd0;
            quo    <= 32'd0;
            dvs    <= 32'd0;
            rem    <= 33'd0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= 32'd0;
            ready  <= 1'b0;
        end else begin
            ready <= (state_nxt == DONE);

            if (state == IDLE && state_nxt == CALC) begin
                quo    <= a_mag;
                dvs    <= b_mag;
                rem    <= 33'd0;
                cnt    <= 5'd0;
                is_rem <= op_i[1];
                neg_q  <= op_signed && (dividend_i[31] ^ divisor_i[31]);
                neg_r  <= op_signed && dividend_i[31];
            end else if (state == CALC) begin
                quo <= quo_step;
                rem <= rem_step;
                cnt <= cnt + 5'd1;
            end

            // result_o is 0 except in DONE; held unchanged while DONE persists.
            if (state_nxt != DONE)
                result <= 32'd0;
            else if (state == IDLE)
                result <= early_res;
            else if (state == CALC)
                result <= res_fin;
        end
    end

    assign result_o = result;
    assign ready_o  = ready;

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset. No other clocks or resets SHALL exist.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 start_i  input  1  EX stage holds an M-extension divide/remainder op.
REQ-005 op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 dividend_i  input  32  rs1 value; sampled only at start.
REQ-007 divisor_i  input  32  rs2 value; sampled only at start.
REQ-008 annul_i  input  1  flush of the EX-stage instruction.
REQ-009 hold_i  input  1  EX stage frozen by downstream stall (ctrl stall_o[2]).
REQ-010 result_o  output  32  quotient or remainder.
REQ-011 ready_o  output  1  result_o valid.
REQ-012 stallreq_o  output  1  stall request to ctrl (stallreq_ex_i).

Function
REQ-013 The FSM SHALL have exactly the states IDLE, CALC and DONE, plus a 5-bit iteration counter.
REQ-014 IDLE with start_i=1, not annul_i, divisor!=0, no overflow: latch operand magnitudes, signs and op; go to CALC; counter=0.
REQ-015 IDLE with start_i=1 and divisor==0: go directly to DONE. Result: DIV/DIVU 0xFFFFFFFF; REM/REMU the dividend.
REQ-016 IDLE with start_i=1, signed op, dividend 0x80000000, divisor 0xFFFFFFFF: go directly to DONE. Result: DIV 0x80000000; REM 0.
REQ-017 CALC SHALL perform one restoring shift-subtract step per cycle on unsigned 32-bit magnitudes, using a 33-bit partial remainder.
REQ-018 CALC SHALL run exactly 32 cycles, then go to DONE.
REQ-019 Signed ops SHALL take two's-complement magnitudes at start.
REQ-020 Signed quotient SHALL be negated when the operand signs differ. Signed remainder SHALL take the dividend's sign.
REQ-021 Unsigned ops SHALL use the operands unmodified.
REQ-022 DONE SHALL drive ready_o=1 and result_o=the final value.
REQ-023 DONE with hold_i=1 SHALL stay in DONE with result_o stable.
REQ-024 DONE with hold_i=0 SHALL return to IDLE next cycle. ready_o drops to 0 and result_o returns to 0.
REQ-025 stallreq_o SHALL be combinational: 1 when (IDLE and start_i and not annul_i) or in CALC; 0 in DONE and otherwise.
REQ-026 Normal-op latency: start seen in cycle N; CALC in N+1..N+32; DONE in N+33. stallreq_o is 1 for N..N+32 (33 cycles).
REQ-027 Divide-by-zero and overflow latency: DONE in N+1; stallreq_o is 1 only in cycle N.
REQ-028 annul_i=1 in any state SHALL force IDLE next cycle and discard the operation; ready_o is never raised for it.
REQ-029 annul_i=1 SHALL force stallreq_o=0 in the same cycle.
REQ-030 Priority SHALL be rst_n > annul_i > hold_i > start_i.
REQ-031 start_i and operand changes during CALC or DONE SHALL be ignored.
REQ-032 An op asserted in the cycle after DONE exits SHALL be treated as a new operation.

Reset
REQ-033 rst_n=0 at a clock edge SHALL set: state IDLE, counter 0, result_o 0, ready_o 0, internal operand/remainder registers 0.
REQ-034 stallreq_o SHALL be 0 while rst_n=0, regardless of start_i.
REQ-035 Reset during CALC or DONE SHALL abandon the operation with no ready_o pulse afterwards.

Verification
REQ-036 DIV 100 / 0xFFFFFFF9 (-7) at cycle N -> stallreq_o=1 for N..N+32; ready_o=1 and result_o=0xFFFFFFF2 at N+33. REM same operands -> 0x00000002. DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF. REM 0xFFFFFF9C(-100)/7 -> 0xFFFFFFFE.
REQ-037 DIVU 5/0 -> ready_o=1 and result_o=0xFFFFFFFF at N+1; REMU 5/0 -> 0x00000005 at N+1; stallreq_o=1 only at N.
REQ-038 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+1; REM same operands -> 0x00000000 at N+1.
REQ-039 DIV started at N, annul_i=1 at N+10 -> stallreq_o=0 at N+10, IDLE at N+11, ready_o stays 0. A new DIVU 9/3 at N+11 -> 0x00000003 at N+44.
REQ-040 hold_i=1 for N+33..N+35 -> ready_o=1 and result_o stable over N+33..N+36, no restart although start_i stays 1; IDLE at N+37.
REQ-041 rst_n=0 at N+20 of a DIV -> all outputs 0 next cycle; no ready_o until a new start.
